// File: rtl/id_pipe_pkg.sv
// Shared decode constants for the instruction-decode pipeline stage: ALU op/sel codes,
// MIPS opcode/funct values and the decoded control bundle passed from id_decode to id_pipe.
package id_pipe_pkg;

  localparam logic [7:0] AluOpNop = 8'h00;
  localparam logic [7:0] AluOpAnd = 8'h24;
  localparam logic [7:0] AluOpOr  = 8'h25;
  localparam logic [7:0] AluOpXor = 8'h26;
  localparam logic [7:0] AluOpNor = 8'h27;
  localparam logic [7:0] AluOpSll = 8'h7c;
  localparam logic [7:0] AluOpSrl = 8'h02;
  localparam logic [7:0] AluOpSra = 8'h03;

  localparam logic [2:0] AluSelNop   = 3'b000;
  localparam logic [2:0] AluSelLogic = 3'b001;
  localparam logic [2:0] AluSelShift = 3'b010;

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpAndi    = 6'h0c;
  localparam logic [5:0] OpOri     = 6'h0d;
  localparam logic [5:0] OpXori    = 6'h0e;
  localparam logic [5:0] OpLui     = 6'h0f;

  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnXor = 6'h26;
  localparam logic [5:0] FnNor = 6'h27;
  localparam logic [5:0] FnSll = 6'h00;
  localparam logic [5:0] FnSrl = 6'h02;
  localparam logic [5:0] FnSra = 6'h03;

  localparam logic [4:0] NopRegAddr = 5'd0;

  // Register addresses are kept at the 5-bit MIPS field width; id_pipe resizes to REG_AW.
  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic        wreg;
    logic [4:0]  wd;
    logic        instvalid;
    logic        reg1_read;
    logic [4:0]  reg1_addr;
    logic        reg2_read;
    logic [4:0]  reg2_addr;
    logic [31:0] imm;
  } dec_ctrl_t;

endpackage

// File: rtl/id_decode.sv
// Combinational MIPS decoder for the logic/shift subset; unread operands take ctrl_o.imm.
module id_decode
  import id_pipe_pkg::*;
(
  input  logic [31:0] inst_i,
  output dec_ctrl_t   ctrl_o
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [15:0] imm16;

  assign op    = inst_i[31:26];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  assign sa    = inst_i[10:6];
  assign funct = inst_i[5:0];
  assign imm16 = inst_i[15:0];

  always_comb begin
    ctrl_o        = '0;
    ctrl_o.aluop  = AluOpNop;
    ctrl_o.alusel = AluSelNop;
    ctrl_o.wd     = NopRegAddr;
    if (inst_i == '0) begin
      // The canonical NOP encoding is valid but writes nothing.
      ctrl_o.instvalid = 1'b1;
    end else begin
      case (op)
        OpAndi, OpOri, OpXori: begin
          ctrl_o.instvalid = 1'b1;
          ctrl_o.wreg      = 1'b1;
          ctrl_o.wd        = rt;
          ctrl_o.reg1_read = 1'b1;
          ctrl_o.reg1_addr = rs;
          ctrl_o.imm       = {16'h0000, imm16};
          ctrl_o.alusel    = AluSelLogic;
          ctrl_o.aluop     = (op == OpAndi) ? AluOpAnd : (op == OpOri) ? AluOpOr : AluOpXor;
        end
        OpLui: begin
          // Both operands take the shifted immediate, so OR yields imm16<<16.
          ctrl_o.instvalid = 1'b1;
          ctrl_o.wreg      = 1'b1;
          ctrl_o.wd        = rt;
          ctrl_o.imm       = {imm16, 16'h0000};
          ctrl_o.alusel    = AluSelLogic;
          ctrl_o.aluop     = AluOpOr;
        end
        OpSpecial: begin
          case (funct)
            FnAnd, FnOr, FnXor, FnNor: begin
              if (sa == 5'd0) begin
                ctrl_o.instvalid = 1'b1;
                ctrl_o.wreg      = 1'b1;
                ctrl_o.wd        = rd;
                ctrl_o.reg1_read = 1'b1;
                ctrl_o.reg1_addr = rs;
                ctrl_o.reg2_read = 1'b1;
                ctrl_o.reg2_addr = rt;
                ctrl_o.alusel    = AluSelLogic;
                ctrl_o.aluop     = (funct == FnAnd) ? AluOpAnd :
                                   (funct == FnOr)  ? AluOpOr  :
                                   (funct == FnXor) ? AluOpXor : AluOpNor;
              end
            end
            FnSll, FnSrl, FnSra: begin
              if (rs == 5'd0) begin
                ctrl_o.instvalid = 1'b1;
                ctrl_o.wreg      = 1'b1;
                ctrl_o.wd        = rd;
                ctrl_o.reg2_read = 1'b1;
                ctrl_o.reg2_addr = rt;
                ctrl_o.imm       = {27'd0, sa};
                ctrl_o.alusel    = AluSelShift;
                ctrl_o.aluop     = (funct == FnSll) ? AluOpSll :
                                   (funct == FnSrl) ? AluOpSrl : AluOpSra;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/id_pipe.sv
// Decode pipeline stage: operand selection, hazard stall and a valid/ready output register.
// Define ID_PIPE_FWD_EN to forward EX/MEM results; otherwise any EX/MEM write match stalls.
module id_pipe
  import id_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       pc_i,
  input  logic [31:0]       inst_i,
  output logic              reg1_read_o,
  output logic              reg2_read_o,
  output logic [REG_AW-1:0] reg1_addr_o,
  output logic [REG_AW-1:0] reg2_addr_o,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,
  input  logic              ex_wreg_i,
  input  logic [REG_AW-1:0] ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              ex_is_load_i,
  input  logic              mem_wreg_i,
  input  logic [REG_AW-1:0] mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              flush_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        aluop_o,
  output logic [2:0]        alusel_o,
  output logic [DATA_W-1:0] reg1_o,
  output logic [DATA_W-1:0] reg2_o,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic [31:0]       pc_o,
  output logic              instvalid_o
);

  dec_ctrl_t ctrl;

  id_decode u_decode (
    .inst_i (inst_i),
    .ctrl_o (ctrl)
  );

  logic              rd_en   [2];
  logic [REG_AW-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];
  logic [DATA_W-1:0] opnd    [2];
  logic              hazard  [2];
  logic [DATA_W-1:0] imm;
  logic              stall;
  logic              accept;

  assign rd_en[0]   = ctrl.reg1_read & in_valid & ~rst;
  assign rd_en[1]   = ctrl.reg2_read & in_valid & ~rst;
  assign rd_addr[0] = REG_AW'(ctrl.reg1_addr);
  assign rd_addr[1] = REG_AW'(ctrl.reg2_addr);
  assign rd_data[0] = reg1_data_i;
  assign rd_data[1] = reg2_data_i;
  assign imm        = DATA_W'(ctrl.imm);

  assign reg1_read_o = rd_en[0];
  assign reg2_read_o = rd_en[1];
  assign reg1_addr_o = rd_addr[0];
  assign reg2_addr_o = rd_addr[1];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hazard[i] = 1'b0;
      opnd[i]   = imm;
      if (rd_en[i]) begin
        if (rd_addr[i] == '0) begin
          opnd[i] = '0;
`ifdef ID_PIPE_FWD_EN
        end else if (ex_wreg_i && (ex_wd_i == rd_addr[i])) begin
          // EX wins over MEM; a load in EX has no data yet, so wait for it to reach MEM.
          opnd[i]   = ex_wdata_i;
          hazard[i] = ex_is_load_i;
        end else if (mem_wreg_i && (mem_wd_i == rd_addr[i])) begin
          opnd[i] = mem_wdata_i;
        end else begin
          opnd[i] = rd_data[i];
        end
`else
        end else begin
          opnd[i]   = rd_data[i];
          hazard[i] = (ex_wreg_i && (ex_wd_i == rd_addr[i])) ||
                      (mem_wreg_i && (mem_wd_i == rd_addr[i]));
        end
`endif
      end
    end
  end

`ifndef ID_PIPE_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{ex_wdata_i, mem_wdata_i, ex_is_load_i};
`endif

  logic              out_valid_q, out_valid_d;
  logic [7:0]        aluop_q, aluop_d;
  logic [2:0]        alusel_q, alusel_d;
  logic [DATA_W-1:0] reg1_q, reg1_d;
  logic [DATA_W-1:0] reg2_q, reg2_d;
  logic [REG_AW-1:0] wd_q, wd_d;
  logic              wreg_q, wreg_d;
  logic [31:0]       pc_q, pc_d;
  logic              instvalid_q, instvalid_d;

  assign stall    = hazard[0] | hazard[1];
  assign in_ready = ~rst & ~stall & (out_ready | ~out_valid_q);
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    aluop_d     = aluop_q;
    alusel_d    = alusel_q;
    reg1_d      = reg1_q;
    reg2_d      = reg2_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    pc_d        = pc_q;
    instvalid_d = instvalid_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      aluop_d     = ctrl.aluop;
      alusel_d    = ctrl.alusel;
      reg1_d      = opnd[0];
      reg2_d      = opnd[1];
      wd_d        = REG_AW'(ctrl.wd);
      wreg_d      = ctrl.wreg;
      pc_d        = pc_i;
      instvalid_d = ctrl.instvalid;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      aluop_q     <= AluOpNop;
      alusel_q    <= AluSelNop;
      reg1_q      <= '0;
      reg2_q      <= '0;
      wd_q        <= REG_AW'(NopRegAddr);
      wreg_q      <= 1'b0;
      pc_q        <= '0;
      instvalid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      aluop_q     <= aluop_d;
      alusel_q    <= alusel_d;
      reg1_q      <= reg1_d;
      reg2_q      <= reg2_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      pc_q        <= pc_d;
      instvalid_q <= instvalid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign aluop_o     = aluop_q;
  assign alusel_o    = alusel_q;
  assign reg1_o      = reg1_q;
  assign reg2_o      = reg2_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign pc_o        = pc_q;
  assign instvalid_o = instvalid_q;

endmodule

// File: tb/tb_id_pipe.sv
// Bench for id_pipe: directed vectors plus a cycle-level model checked every negedge.
// Expectations follow ID_PIPE_FWD_EN when it is defined for the build.
module tb_id_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] pc_i, inst_i;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
  logic [4:0]  ex_wd_i, mem_wd_i;
  logic [31:0] ex_wdata_i, mem_wdata_i;
  logic        flush_i, out_valid, out_ready;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic [31:0] reg1_o, reg2_o, pc_o;
  logic [4:0]  wd_o;
  logic        wreg_o, instvalid_o;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [31:0] rf [32];
  assign reg1_data_i = rf[reg1_addr_o];
  assign reg2_data_i = rf[reg2_addr_o];

  always #5 clk = ~clk;

  id_pipe #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc_i(pc_i),
    .inst_i(inst_i), .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o), .reg1_data_i(reg1_data_i),
    .reg2_data_i(reg2_data_i), .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i),
    .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i), .mem_wreg_i(mem_wreg_i),
    .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i), .flush_i(flush_i),
    .out_valid(out_valid), .out_ready(out_ready), .aluop_o(aluop_o), .alusel_o(alusel_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o),
    .instvalid_o(instvalid_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic        wreg;
    logic [4:0]  wd;
    logic        iv;
    logic        r1;
    logic [4:0]  a1;
    logic        r2;
    logic [4:0]  a2;
    logic [31:0] imm;
  } dec_t;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] pc;
    logic        iv;
  } rec_t;

  function automatic dec_t m_decode(input logic [31:0] inst);
    dec_t d;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sa;
    op = inst[31:26]; rs = inst[25:21]; rt = inst[20:16];
    rd = inst[15:11]; sa = inst[10:6];  fn = inst[5:0];
    d = '0;
    if (inst == 32'h0) begin
      d.iv = 1'b1;
    end else if (op == 6'h0c || op == 6'h0d || op == 6'h0e) begin
      d.iv = 1'b1; d.wreg = 1'b1; d.wd = rt; d.r1 = 1'b1; d.a1 = rs;
      d.imm = {16'h0, inst[15:0]}; d.alusel = 3'd1;
      d.aluop = (op == 6'h0c) ? 8'h24 : (op == 6'h0d) ? 8'h25 : 8'h26;
    end else if (op == 6'h0f) begin
      d.iv = 1'b1; d.wreg = 1'b1; d.wd = rt; d.imm = {inst[15:0], 16'h0};
      d.alusel = 3'd1; d.aluop = 8'h25;
    end else if (op == 6'h00 && sa == 5'd0 && fn >= 6'h24 && fn <= 6'h27) begin
      d.iv = 1'b1; d.wreg = 1'b1; d.wd = rd; d.r1 = 1'b1; d.a1 = rs;
      d.r2 = 1'b1; d.a2 = rt; d.alusel = 3'd1; d.aluop = {2'b00, fn};
    end else if (op == 6'h00 && rs == 5'd0 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)) begin
      d.iv = 1'b1; d.wreg = 1'b1; d.wd = rd; d.r2 = 1'b1; d.a2 = rt;
      d.imm = {27'd0, sa}; d.alusel = 3'd2;
      d.aluop = (fn == 6'h00) ? 8'h7c : {2'b00, fn};
    end
    return d;
  endfunction

  function automatic logic m_haz(input logic rd, input logic [4:0] a);
    if (!rd || a == 5'd0) return 1'b0;
`ifdef ID_PIPE_FWD_EN
    return ex_is_load_i && ex_wreg_i && ex_wd_i == a;
`else
    return (ex_wreg_i && ex_wd_i == a) || (mem_wreg_i && mem_wd_i == a);
`endif
  endfunction

  function automatic logic [31:0] m_opnd(input logic rd, input logic [4:0] a,
                                         input logic [31:0] imm);
    if (!rd) return imm;
    if (a == 5'd0) return 32'h0;
`ifdef ID_PIPE_FWD_EN
    if (ex_wreg_i && ex_wd_i == a) return ex_wdata_i;
    if (mem_wreg_i && mem_wd_i == a) return mem_wdata_i;
`endif
    return rf[a];
  endfunction

  logic m_valid = 1'b0;
  rec_t m_rec;

  function automatic logic m_ready();
    dec_t d;
    logic stall;
    d = m_decode(inst_i);
    stall = in_valid && (m_haz(d.r1, d.a1) || m_haz(d.r2, d.a2));
    return !rst && !stall && (out_ready || !m_valid);
  endfunction

  always @(posedge clk) begin : model
    dec_t d;
    d = m_decode(inst_i);
    if (rst) begin
      m_valid = 1'b0;
      m_rec   = '0;
    end else if (flush_i) begin
      m_valid = 1'b0;
    end else if (in_valid && m_ready()) begin
      m_valid       = 1'b1;
      m_rec.aluop   = d.aluop;
      m_rec.alusel  = d.alusel;
      m_rec.reg1    = m_opnd(d.r1, d.a1, d.imm);
      m_rec.reg2    = m_opnd(d.r2, d.a2, d.imm);
      m_rec.wd      = d.wd;
      m_rec.wreg    = d.wreg;
      m_rec.pc      = pc_i;
      m_rec.iv      = d.iv;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin : monitor
    dec_t d;
    if (mon_en) begin
      d = m_decode(inst_i);
      chk("m_in_ready", in_ready, m_ready());
      chk("m_rd1_en", reg1_read_o, !rst && in_valid && d.r1);
      chk("m_rd2_en", reg2_read_o, !rst && in_valid && d.r2);
      if (!rst && in_valid && d.r1) chk("m_rd1_addr", reg1_addr_o, d.a1);
      if (!rst && in_valid && d.r2) chk("m_rd2_addr", reg2_addr_o, d.a2);
      chk("m_out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("m_aluop", aluop_o, m_rec.aluop);
        chk("m_alusel", alusel_o, m_rec.alusel);
        chk("m_reg1", reg1_o, m_rec.reg1);
        chk("m_reg2", reg2_o, m_rec.reg2);
        chk("m_wd", wd_o, m_rec.wd);
        chk("m_wreg", wreg_o, m_rec.wreg);
        chk("m_pc", pc_o, m_rec.pc);
        chk("m_instvalid", instvalid_o, m_rec.iv);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  localparam logic [31:0] IOri1  = 32'h3401_1100;  // ori  $1,$0,0x1100
  localparam logic [31:0] IAnd3  = 32'h0022_1824;  // and  $3,$1,$2
  localparam logic [31:0] IOri4  = 32'h3444_0001;  // ori  $4,$2,1
  localparam logic [31:0] ILui5  = 32'h3C05_ABCD;  // lui  $5,0xabcd
  localparam logic [31:0] ISll6  = 32'h0002_3100;  // sll  $6,$2,4
  localparam logic [31:0] ISra7  = 32'h0003_3FC3;  // sra  $7,$3,31
  localparam logic [31:0] ISrl9  = 32'h0003_4882;  // srl  $9,$3,2
  localparam logic [31:0] IXori8 = 32'h3928_FFFF;  // xori $8,$9,0xffff
  localparam logic [31:0] INor10 = 32'h016C_5027;  // nor  $10,$11,$12
  localparam logic [31:0] IAndi  = 32'h302B_8001;  // andi $11,$1,0x8001
  localparam logic [31:0] IOrZ   = 32'h000E_6825;  // or   $13,$0,$14
  localparam logic [31:0] IBadSh = 32'h0042_0100;  // sll with rs!=0
  localparam logic [31:0] IBadOp = 32'hFC00_0000;  // opcode 0x3f

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; inst_i = inst; pc_i = pc;
    for (int n = 0; n < 20 && !ok; n++) begin
      #1;
      if (in_ready) ok = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    chk("send_accept", ok, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0101_0101 * i;
    rf[0] = 32'hDEAD_BEEF;
    rf[2] = 32'h0000_FF00;
    rst = 1'b1; in_valid = 1'b1; inst_i = IOri1; pc_i = 32'h0; out_ready = 1'b1;
    flush_i = 1'b0; ex_wreg_i = 1'b0; ex_wd_i = '0; ex_wdata_i = '0; ex_is_load_i = 1'b0;
    mem_wreg_i = 1'b0; mem_wd_i = '0; mem_wdata_i = '0;
    cyc();
    mon_en = 1'b1;
    cyc();
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_rd1_en", reg1_read_o, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    rst = 1'b0; in_valid = 1'b0;
    cyc();

    // ORI $1,$0,0x1100
    send(IOri1, 32'h100);
    chk("ori_valid", out_valid, 1'b1);
    chk("ori_reg1", reg1_o, 32'h0);
    chk("ori_reg2", reg2_o, 32'h0000_1100);
    chk("ori_wd", wd_o, 5'd1);
    chk("ori_wreg", wreg_o, 1'b1);
    chk("ori_aluop", aluop_o, 8'h25);
    chk("ori_pc", pc_o, 32'h100);

    // AND $3,$1,$2 with EX and MEM both writing $1
    ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_wdata_i = 32'hF0F0;
    mem_wreg_i = 1'b1; mem_wd_i = 5'd1; mem_wdata_i = 32'h1234;
`ifdef ID_PIPE_FWD_EN
    send(IAnd3, 32'h104);
    chk("and_reg1", reg1_o, 32'hF0F0);
    chk("and_reg2", reg2_o, 32'hFF00);
`else
    in_valid = 1'b1; inst_i = IAnd3; pc_i = 32'h104;
    #1 chk("and_stall_ex", in_ready, 1'b0);
    cyc();
    chk("and_bubble", out_valid, 1'b0);
    ex_wreg_i = 1'b0;
    #1 chk("and_stall_mem", in_ready, 1'b0);
    cyc();
    mem_wreg_i = 1'b0;
    send(IAnd3, 32'h104);
    chk("and_reg1", reg1_o, 32'h0101_0101);
    chk("and_reg2", reg2_o, 32'hFF00);
`endif
    ex_wreg_i = 1'b0; mem_wreg_i = 1'b0;

    // Load-use on $2, then the loaded value arrives from MEM
    ex_is_load_i = 1'b1; ex_wreg_i = 1'b1; ex_wd_i = 5'd2; ex_wdata_i = 32'h5555;
    in_valid = 1'b1; inst_i = IOri4; pc_i = 32'h108;
    #1 chk("lu_in_ready", in_ready, 1'b0);
    cyc();
    chk("lu_bubble", out_valid, 1'b0);
    ex_is_load_i = 1'b0; ex_wreg_i = 1'b0;
    mem_wreg_i = 1'b1; mem_wd_i = 5'd2; mem_wdata_i = 32'hCAFE;
`ifdef ID_PIPE_FWD_EN
    send(IOri4, 32'h108);
    chk("lu_reg1", reg1_o, 32'hCAFE);
`else
    #1 chk("lu_mem_stall", in_ready, 1'b0);
    cyc();
    mem_wreg_i = 1'b0;
    send(IOri4, 32'h108);
    chk("lu_reg1", reg1_o, 32'hFF00);
`endif
    chk("lu_reg2", reg2_o, 32'h1);
    chk("lu_wd", wd_o, 5'd4);
    mem_wreg_i = 1'b0;

    // Back-pressure for three cycles, next instruction waiting
    send(ILui5, 32'h10C);
    out_ready = 1'b0;
    in_valid = 1'b1; inst_i = ISll6; pc_i = 32'h110;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_reg2", reg2_o, 32'hABCD_0000);
      chk("bp_pc", pc_o, 32'h10C);
      cyc();
    end
    out_ready = 1'b1;
    #1 chk("bp_release", in_ready, 1'b1);
    cyc();
    in_valid = 1'b0;
    chk("sll_pc", pc_o, 32'h110);
    chk("sll_reg1", reg1_o, 32'd4);
    chk("sll_reg2", reg2_o, 32'hFF00);
    chk("sll_aluop", aluop_o, 8'h7c);

    send(ISra7, 32'h114);
    send(ISrl9, 32'h118);
    send(IXori8, 32'h11C);
    chk("xori_reg2", reg2_o, 32'h0000_FFFF);
    send(INor10, 32'h120);
    send(IAndi, 32'h124);
    send(IOrZ, 32'h128);
    chk("orz_reg1", reg1_o, 32'h0);
    send(32'h0, 32'h12C);
    chk("nop_iv", instvalid_o, 1'b1);
    chk("nop_wreg", wreg_o, 1'b0);
    chk("nop_aluop", aluop_o, 8'h00);
    send(IBadSh, 32'h130);
    chk("badsh_iv", instvalid_o, 1'b0);
    send(IBadOp, 32'h134);
    chk("badop_iv", instvalid_o, 1'b0);
    chk("badop_wreg", wreg_o, 1'b0);
    chk("badop_alusel", alusel_o, 3'd0);

    // Flush during acceptance, then flush of a held instruction under back-pressure
    cyc();
    in_valid = 1'b1; inst_i = IXori8; pc_i = 32'h138; flush_i = 1'b1;
    #1 chk("fl_in_ready", in_ready, 1'b1);
    cyc();
    flush_i = 1'b0; in_valid = 1'b0;
    chk("fl_valid", out_valid, 1'b0);
    send(IOri1, 32'h13C);
    out_ready = 1'b0; flush_i = 1'b1;
    cyc();
    flush_i = 1'b0; out_ready = 1'b1;
    chk("fl_held_valid", out_valid, 1'b0);

    // Reset while holding a valid instruction and offering another
    send(INor10, 32'h140);
    chk("pre_rst_valid", out_valid, 1'b1);
    rst = 1'b1; in_valid = 1'b1; inst_i = IXori8; pc_i = 32'h144;
    cyc();
    chk("rst2_valid", out_valid, 1'b0);
    chk("rst2_wreg", wreg_o, 1'b0);
    chk("rst2_iv", instvalid_o, 1'b0);
    chk("rst2_reg1", reg1_o, 32'h0);
    chk("rst2_reg2", reg2_o, 32'h0);
    chk("rst2_pc", pc_o, 32'h0);
    chk("rst2_wd", wd_o, 5'd0);
    chk("rst2_aluop", aluop_o, 8'h00);
    chk("rst2_alusel", alusel_o, 3'd0);
    rst = 1'b0; in_valid = 1'b0;
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
